// File: rtl/alloc_steer_pkg.sv
// Shared types for the allocation/dispatch stage: uop, rename and dispatch packets,
// plus dispatch-port numbering.
package alloc_steer_pkg;

  localparam int NUM_DISP_PORTS = 2;
  localparam int DISP_PORT_EINT = 0;
  localparam int DISP_PORT_MEM  = 1;

  localparam int NUM_SOURCES = 2;
  localparam int SRC1        = 0;
  localparam int SRC2        = 1;

  typedef logic [$clog2(NUM_DISP_PORTS)-1:0] t_disp_port;
  typedef logic [4:0] t_rv_reg_addr;
  typedef logic [4:0] t_rob_id;
  typedef logic [5:0] t_preg;

  typedef struct packed {
    logic         vld;
    t_rv_reg_addr opreg;
  } t_src_op;

  typedef struct packed {
    logic         valid;
    logic [7:0]   opcode;
    t_src_op      src1;
    t_src_op      src2;
    t_rv_reg_addr dst;
    logic [7:0]   imm;
  } t_uinstr;

  typedef struct packed {
    t_preg psrc1;
    t_preg psrc2;
    t_preg pdst;
  } t_rename_pkt;

  typedef struct packed {
    t_uinstr     uinstr;
    t_rob_id     robid;
    t_rename_pkt rename;
  } t_uinstr_disp;

endpackage

// File: rtl/alloc_credit_ctr.sv
// Per-port RS credit counter: starts full, decrements on dispatch, increments on
// return, and saturates (flagging overflow_err) on a return while already full.
module alloc_credit_ctr #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec,
  input  logic                         inc,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         nonzero,
  output logic                         overflow_err
);

  localparam int CW = $clog2(DEPTH+1);

  assign nonzero      = (cnt != '0);
  assign overflow_err = inc & ~dec & (cnt == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CW'(DEPTH);
    end else if (inc & ~dec & ~overflow_err) begin
      cnt <= cnt + CW'(1);
    end else if (dec & ~inc) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alloc_steer.sv
// Allocation/dispatch stage: accepts one uop per cycle at RA0, claims a ROB id,
// holds it in RA1 and steers it to one of NUM_PORTS credit-controlled RS ports.
module alloc_steer
  import alloc_steer_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int RS_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  t_uinstr               uinstr_ra0,
  input  t_rename_pkt           rename_ra0,
  input  t_disp_port            disp_port_ra0,
  input  t_rob_id               next_robid_ra0,
  input  logic                  rob_full_ra0,
  input  logic                  flush,
  output t_rv_reg_addr          src_addr_ra0 [NUM_SOURCES],
  output logic                  stall_ra0,
  output logic                  rob_alloc_ra0,
  input  logic [NUM_PORTS-1:0]  rs_credit_ret,
  output logic [NUM_PORTS-1:0]  disp_valid_rs0,
  output t_uinstr_disp          disp_rs0 [NUM_PORTS]
);

  localparam int CW = $clog2(RS_DEPTH+1);

  logic                 ra1_vld;
  t_uinstr_disp         ra1_pkt;
  t_disp_port           ra1_port;
  logic [CW-1:0]        credit [NUM_PORTS];
  logic [NUM_PORTS-1:0] credit_nz;
  logic [NUM_PORTS-1:0] ovf_err;
  logic                 ra0_port_ok;
  logic                 ra1_port_ok;
  logic                 can_disp;
  logic                 accept;

  // Port range checks only exist when the port field can encode unused indices.
  if ((2 ** $bits(t_disp_port)) > NUM_PORTS) begin : g_port_chk
    assign ra0_port_ok = int'(disp_port_ra0) < NUM_PORTS;
    assign ra1_port_ok = int'(ra1_port) < NUM_PORTS;
  end else begin : g_port_all_ok
    assign ra0_port_ok = 1'b1;
    assign ra1_port_ok = 1'b1;
  end

  // Stall is a function of registered state and rob_full only, so it never
  // closes a combinational loop back into rename.
  assign can_disp      = ra1_vld & ra1_port_ok & credit_nz[ra1_port];
  assign stall_ra0     = (ra1_vld & ~can_disp) | rob_full_ra0;
  assign accept        = uinstr_ra0.valid & ~stall_ra0 & ~flush;
  assign rob_alloc_ra0 = accept;

  assign src_addr_ra0[SRC1] = uinstr_ra0.src1.opreg;
  assign src_addr_ra0[SRC2] = uinstr_ra0.src2.opreg;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign disp_valid_rs0[p] = can_disp & (ra1_port == t_disp_port'(p)) & ~flush;
    assign disp_rs0[p]       = ra1_pkt;

    alloc_credit_ctr #(.DEPTH(RS_DEPTH)) u_ctr (
      .clk          (clk),
      .reset        (reset),
      .dec          (disp_valid_rs0[p]),
      .inc          (rs_credit_ret[p]),
      .cnt          (credit[p]),
      .nonzero      (credit_nz[p]),
      .overflow_err (ovf_err[p])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_vld  <= 1'b0;
      ra1_pkt  <= '0;
      ra1_port <= '0;
    end else begin
      if (flush) begin
        ra1_vld <= 1'b0;
      end else if (accept) begin
        ra1_vld <= 1'b1;
      end else if (can_disp) begin
        ra1_vld <= 1'b0;
      end
      if (accept) begin
        ra1_pkt  <= '{uinstr: uinstr_ra0, robid: next_robid_ra0, rename: rename_ra0};
        ra1_port <= disp_port_ra0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (ovf_err == '0);
      assert (!(accept && !ra0_port_ok));
      assert ($onehot0(disp_valid_rs0));
    end
  end

endmodule
